// File: rtl/vga_timing_gen.sv
// Parametrised VESA-style video timing generator: pixel/line counters, sync, blanking, DE and line/frame strobes.
// Optional 16-bit frame counter output is enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 40,
  parameter int unsigned H_SYNC   = 128,
  parameter int unsigned H_BP     = 88,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 1,
  parameter int unsigned V_SYNC   = 4,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned H_POL    = 1,
  parameter int unsigned V_POL    = 1,
  parameter int unsigned CW       = 11
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          ce,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          hsync,
  output logic          vsync,
  output logic          hblnk,
  output logic          vblnk,
  output logic          de,
  output logic          line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
  output logic          frame_start,
  output logic [15:0]   frame_cnt
`else
  output logic          frame_start
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
  localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);

  localparam logic HS_ON = (H_POL != 0);
  localparam logic VS_ON = (V_POL != 0);

  // Reject degenerate timings and counters too narrow to hold a full line/frame.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || CW < 1) begin : g_param_min_err
    $error("vga_timing_gen: timing parameters and CW must all be >= 1");
  end
  if (longint'(H_TOTAL) > (64'd1 << CW) || longint'(V_TOTAL) > (64'd1 << CW)) begin : g_param_cw_err
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end

  logic          h_last;
  logic          v_last;
  logic [CW-1:0] h_next;
  logic [CW-1:0] v_next;

  // Next counter position; every registered decode is taken from these values.
  always_comb begin
    h_last = (hcount == H_LAST_C);
    v_last = (vcount == V_LAST_C);
    h_next = h_last ? '0 : hcount + CW'(1);
    v_next = vcount;
    if (h_last) begin
      v_next = v_last ? '0 : vcount + CW'(1);
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      de          <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcount      <= h_next;
      vcount      <= v_next;
      hsync       <= ((h_next >= HS_START_C) && (h_next < HS_END_C)) ? HS_ON : ~HS_ON;
      vsync       <= ((v_next >= VS_START_C) && (v_next < VS_END_C)) ? VS_ON : ~VS_ON;
      hblnk       <= (h_next >= H_ACTIVE_C);
      vblnk       <= (v_next >= V_ACTIVE_C);
      de          <= (h_next < H_ACTIVE_C) && (v_next < V_ACTIVE_C);
      line_start  <= h_last;
      frame_start <= h_last && v_last;
    end else begin
      // Strobes are single-pclk even when ce stays low afterwards.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (ce && h_last && v_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule
